vanilla_barrier_seq: RTL and testbench

//  Sequences barsend/barrecv for one vanilla core against the barrier CSRs (Pi/Po).

---
 rtl/bsg_vanilla_pkg.sv | 10 +
 rtl/bsg_counter_clear_up.sv | 31 +++
 rtl/vanilla_barrier_seq.sv | 121 ++++++++++++
 tb/tb_vanilla_barrier_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core barrier sequencing logic.
package bsg_vanilla_pkg;

  typedef enum logic [1:0] {
    eBarIdle  = 2'd0,
    eBarArmed = 2'd1,
    eBarWait  = 2'd2
  } barrier_seq_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Wrapping up-counter with synchronous reset and synchronous clear.
module bsg_counter_clear_up #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] one_lp = width_p'(1);

  logic [width_p-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) count_d = '0;
    if (up_i)    count_d = count_d + one_lp;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/vanilla_barrier_seq.sv
// Sequences barsend/barrecv for one vanilla core against the Pi/Po barrier bits:
// forwards the Pi toggle, stalls barrecv until Po==Pi, flags errors/timeouts, counts barriers.
module vanilla_barrier_seq
  import bsg_vanilla_pkg::*;
#(
  parameter int timeout_cycles_p = 0,
  parameter int wait_cnt_width_p = 16,
  parameter int bar_cnt_width_p  = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        barsend_v_i,
  input  logic                        barrecv_v_i,
  input  logic                        csr_pi_we_i,
  input  logic                        pi_r_i,
  input  logic                        po_i,
  output logic                        barsend_o,
  output logic                        stall_o,
  output logic                        err_o,
  output logic                        timeout_o,
  output logic [wait_cnt_width_p-1:0] wait_cnt_o,
  output logic [bar_cnt_width_p-1:0]  bar_cnt_o
);

  localparam logic [wait_cnt_width_p-1:0] wait_one_lp = wait_cnt_width_p'(1);
  localparam logic [wait_cnt_width_p-1:0] timeout_lp  = wait_cnt_width_p'(timeout_cycles_p);
  // A threshold the saturating counter can never reach is treated as disabled.
  localparam bit timeout_en_lp = (timeout_cycles_p > 0) &&
    (longint'(timeout_cycles_p) < (longint'(1) << wait_cnt_width_p));

  barrier_seq_state_e state_q, state_d;
  logic err_q, err_d;
  logic timeout_q, timeout_d;
  logic [wait_cnt_width_p-1:0] wait_cnt_q, wait_cnt_d;

  logic po_match;
  logic send_fwd;
  logic stall;
  logic complete;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;
    stall      = 1'b0;
    complete   = 1'b0;

    po_match = (po_i == pi_r_i);
    // A CSR write to Pi in the same cycle wins over barsend.
    send_fwd = barsend_v_i & ~csr_pi_we_i & (state_q != eBarWait);

    if (barsend_v_i & csr_pi_we_i)             err_d = 1'b1;
    if (csr_pi_we_i & (state_q != eBarIdle))   err_d = 1'b1;
    if (send_fwd & (state_q == eBarArmed))     err_d = 1'b1;

    case (state_q)
      eBarWait: begin
        stall = ~po_match;
        if (!barrecv_v_i) begin
          err_d   = 1'b1;
          state_d = eBarIdle;
        end else if (po_match) begin
          complete = 1'b1;
          state_d  = eBarIdle;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + wait_one_lp;
        end
      end
      default: begin
        if (barrecv_v_i) begin
          stall = ~po_match;
          if (po_match) begin
            complete = 1'b1;
            state_d  = eBarIdle;
          end else begin
            state_d    = eBarWait;
            wait_cnt_d = wait_one_lp;
          end
        end else if (send_fwd) begin
          state_d = eBarArmed;
        end
      end
    endcase

    // Timeout only flags; the stall is still released by Po alone.
    if (timeout_en_lp && (wait_cnt_d == timeout_lp)) timeout_d = 1'b1;

    barsend_o = send_fwd & ~reset_i;
    stall_o   = stall & ~reset_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eBarIdle;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  bsg_counter_clear_up #(
    .width_p(bar_cnt_width_p)
  ) bar_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(1'b0),
    .up_i   (complete),
    .count_o(bar_cnt_o)
  );

  assign err_o      = err_q;
  assign timeout_o  = timeout_q;
  assign wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_vanilla_barrier_seq.sv
// Bench for vanilla_barrier_seq: a default instance and a small-width/timeout instance share stimulus.
module tb_vanilla_barrier_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, barsend_v_i, barrecv_v_i, csr_pi_we_i, pi_r_i, po_i;

  logic        bs_a, st_a, err_a, to_a;
  logic [15:0] wc_a, bc_a;
  logic        bs_b, st_b, err_b, to_b;
  logic [3:0]  wc_b;
  logic [1:0]  bc_b;

  vanilla_barrier_seq dut_a (
    .clk_i(clk), .reset_i(reset_i), .barsend_v_i(barsend_v_i), .barrecv_v_i(barrecv_v_i),
    .csr_pi_we_i(csr_pi_we_i), .pi_r_i(pi_r_i), .po_i(po_i),
    .barsend_o(bs_a), .stall_o(st_a), .err_o(err_a), .timeout_o(to_a),
    .wait_cnt_o(wc_a), .bar_cnt_o(bc_a)
  );

  vanilla_barrier_seq #(
    .timeout_cycles_p(8), .wait_cnt_width_p(4), .bar_cnt_width_p(2)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_i), .barsend_v_i(barsend_v_i), .barrecv_v_i(barrecv_v_i),
    .csr_pi_we_i(csr_pi_we_i), .pi_r_i(pi_r_i), .po_i(po_i),
    .barsend_o(bs_b), .stall_o(st_b), .err_o(err_b), .timeout_o(to_b),
    .wait_cnt_o(wc_b), .bar_cnt_o(bc_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: barrier phase as flags, counts as unbounded integers.
  bit pi = 1'b0;
  bit m_armed, m_waiting, m_err, m_to;
  int m_wait, m_bars;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic step(input bit rst, input bit bs, input bit br, input bit we,
                      input bit wd, input bit pov);
    bit e_bs, e_st, match;
    @(negedge clk);
    reset_i = rst; barsend_v_i = bs; barrecv_v_i = br; csr_pi_we_i = we;
    pi_r_i = pi; po_i = pov;
    #1;
    match = (pov == pi);
    e_bs  = !rst && bs && !we && !m_waiting;
    e_st  = !rst && (m_waiting || br) && !match;

    check("a_barsend", bs_a, e_bs);
    check("b_barsend", bs_b, e_bs);
    check("a_stall",   st_a, e_st);
    check("b_stall",   st_b, e_st);
    check("a_err",     err_a, m_err);
    check("b_err",     err_b, m_err);
    check("a_timeout", to_a, 0);
    check("b_timeout", to_b, m_to);
    check("a_wait",    wc_a, sat(m_wait, 65535));
    check("b_wait",    wc_b, sat(m_wait, 15));
    check("a_bar",     bc_a, m_bars % 65536);
    check("b_bar",     bc_b, m_bars % 4);

    if (rst) begin
      m_armed = 0; m_waiting = 0; m_err = 0; m_to = 0; m_wait = 0; m_bars = 0;
    end else begin
      if (bs && we)                        m_err = 1;
      if (we && (m_armed || m_waiting))    m_err = 1;
      if (e_bs && m_armed)                 m_err = 1;
      if (m_waiting) begin
        if (!br) begin
          m_err = 1; m_waiting = 0;
        end else if (match) begin
          m_bars++; m_waiting = 0;
        end else begin
          m_wait++;
        end
      end else if (br) begin
        m_armed = 0;
        if (match) m_bars++;
        else begin
          m_waiting = 1; m_wait = 1;
        end
      end else if (e_bs) begin
        m_armed = 1;
      end
      if (m_wait >= 8) m_to = 1;
      // CSR block: barsend toggles Pi at the edge; a CSR write loads it.
      if (e_bs) pi = ~pi;
      if (we)   pi = wd;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, pi);
    step(0, 0, 0, 0, 0, pi);
  endtask

  typedef struct {
    bit rst, bs, br, we, po_eq;
    bit e_bs, e_st, e_err;
  } vec_t;

  vec_t tbl[$];
  int   stalls;
  bit   po_v;

  initial begin
    reset_i = 1; barsend_v_i = 0; barrecv_v_i = 0; csr_pi_we_i = 0; pi_r_i = 0; po_i = 0;

    // rst bs br we po_eq | e_bs e_st e_err (err is the pre-edge registered value)
    tbl.push_back('{1,0,0,0,1, 0,0,0});
    tbl.push_back('{0,0,0,0,1, 0,0,0});
    tbl.push_back('{0,1,0,0,1, 1,0,0});  // barsend accepted
    tbl.push_back('{0,0,1,0,1, 0,0,0});  // barrecv next cycle, Po already followed
    tbl.push_back('{0,1,0,1,1, 0,0,0});  // barsend with CSR write: suppressed
    tbl.push_back('{0,0,0,0,1, 0,0,1});
    tbl.push_back('{1,0,0,0,1, 0,0,1});
    tbl.push_back('{0,0,0,0,1, 0,0,0});
    tbl.push_back('{0,1,0,0,1, 1,0,0});  // first send
    tbl.push_back('{0,1,0,0,1, 1,0,0});  // double send still forwarded
    tbl.push_back('{0,0,0,0,1, 0,0,1});
    tbl.push_back('{1,0,0,0,1, 0,0,1});
    tbl.push_back('{0,0,0,0,1, 0,0,0});
    tbl.push_back('{0,0,1,0,0, 0,1,0});  // barrecv in IDLE with Po!=Pi stalls
    tbl.push_back('{0,0,1,0,1, 0,0,0});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].bs, tbl[i].br, tbl[i].we, pi, tbl[i].po_eq ? pi : ~pi);
      check($sformatf("tbl%0d_barsend", i), bs_a, tbl[i].e_bs);
      check($sformatf("tbl%0d_stall", i),   st_a, tbl[i].e_st);
      check($sformatf("tbl%0d_err", i),     err_a, tbl[i].e_err);
    end

    // Po lags 5 cycles
    do_reset();
    step(0, 1, 0, 0, 0, ~pi);
    stalls = 0;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, ~pi);
      stalls += int'(st_a);
    end
    step(0, 0, 1, 0, 0, pi);
    check("t2_release", st_a, 0);
    step(0, 0, 0, 0, 0, pi);
    check("t2_stalls", stalls, 5);
    check("t2_wait",   wc_a, 5);
    check("t2_bar",    bc_a, 1);
    step(0, 1, 0, 0, 0, pi);
    check("t2_idle_send", bs_a, 1);
    step(0, 0, 0, 0, 0, pi);
    check("t2_err", err_a, 0);

    // Timeout at 8 with Po lagging 20 cycles
    do_reset();
    step(0, 1, 0, 0, 0, ~pi);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 1, 0, 0, ~pi);
      check($sformatf("t3_stall%0d", k), st_b, 1);
      check($sformatf("t3_timeout%0d", k), to_b, (k >= 9) ? 1 : 0);
    end
    step(0, 0, 1, 0, 0, pi);
    check("t3_release", st_b, 0);
    step(0, 0, 0, 0, 0, pi);
    check("t3_bar",     bc_b, 1);
    check("t3_timeout", to_b, 1);
    check("t3_no_to_a", to_a, 0);

    // Saturation of the 4-bit wait counter
    do_reset();
    step(0, 1, 0, 0, 0, ~pi);
    for (int k = 0; k < 40; k++) step(0, 0, 1, 0, 0, ~pi);
    step(0, 0, 1, 0, 0, pi);
    step(0, 0, 0, 0, 0, pi);
    check("t7_wait_b", wc_b, 15);
    check("t7_wait_a", wc_a, 40);

    // Reset in the middle of WAIT
    do_reset();
    step(0, 1, 0, 0, 0, ~pi);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, ~pi);
    step(1, 0, 1, 0, 0, ~pi);
    check("t6_stall_a", st_a, 0);
    check("t6_stall_b", st_b, 0);
    step(0, 0, 0, 0, 0, pi);
    check("t6_err",  err_a, 0);
    check("t6_wait", wc_a, 0);
    check("t6_bar",  bc_a, 0);
    check("t6_to",   to_b, 0);
    step(0, 1, 0, 0, 0, pi);
    check("t6_send", bs_a, 1);
    step(0, 0, 1, 0, 0, pi);
    check("t6_nostall", st_a, 0);
    step(0, 0, 0, 0, 0, pi);
    check("t6_bar_after", bc_a, 1);

    // Five barriers wrap the 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0, 0, pi);
      step(0, 0, 1, 0, 0, pi);
    end
    step(0, 0, 0, 0, 0, pi);
    check("t8_bar_b", bc_b, 1);
    check("t8_bar_a", bc_a, 5);
    check("t8_err",   err_a, 0);

    // Randomized traffic against the model
    do_reset();
    po_v = pi;
    for (int c = 0; c < 3000; c++) begin
      bit rst, bs, br, we, wd;
      int r;
      rst = ($urandom_range(199) == 0);
      wd  = 1'($urandom_range(1));
      bs = 0; br = 0; we = 0;
      if (m_waiting) begin
        br = ($urandom_range(19) != 0);
        bs = ($urandom_range(7) == 0);
        we = ($urandom_range(29) == 0);
      end else begin
        r = $urandom_range(9);
        case (r)
          0, 1, 2: bs = 1;
          3, 4, 5: br = 1;
          6:       we = 1;
          7:       begin bs = 1; we = 1; end
          default: ;
        endcase
      end
      if ($urandom_range(2) == 0) po_v = pi;
      step(rst, bs, br, we, wd, po_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
